// File: rtl/axistream_packet_snooper.sv
// Passive AXI-Stream tap: copies whole packets into a packet memory and reports each packet's byte length.
// Optional SNOOP_STATS_EN adds saturating stored/dropped packet counters.
module axistream_packet_snooper #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 9,
    parameter int WAIT_FOR_SOP = 1,
    parameter int LEN_WIDTH    = ADDR_WIDTH + $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   TDATA,
    input  logic [DATA_WIDTH/8-1:0] TKEEP,
    input  logic                    TVALID,
    input  logic                    TREADY,
    input  logic                    TLAST,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_en,
    input  logic                    mem_ready,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    byte_len,
    output logic                    trunc,
    output logic                    drop,
    output logic [31:0]             pkt_count,
    output logic [31:0]             drop_count
);

    localparam int BPB = DATA_WIDTH / 8;

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;
    localparam logic [1:0] ST_RESET   = (WAIT_FOR_SOP != 0) ? ST_SYNC : ST_IDLE;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [LEN_WIDTH-1:0]  BPB_LEN   = LEN_WIDTH'(BPB);
    localparam logic [LEN_WIDTH-1:0]  FULL_LEN  = BPB_LEN << ADDR_WIDTH;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [BPB-1:0] keep);
        logic [LEN_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < BPB; i++) begin
            cnt = cnt + {{(LEN_WIDTH-1){1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  beat;
    logic [LEN_WIDTH-1:0]  tlast_len;

    assign beat      = TVALID && TREADY;
    assign tlast_len = LEN_WIDTH'(addr) * BPB_LEN + popcount(TKEEP);
    assign wr_addr   = addr;
    assign wr_data   = TDATA;

    // Outputs are decoded from the current state and this cycle's beat, so the write happens with no latency.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        wr_en     = 1'b0;
        done      = 1'b0;
        trunc     = 1'b0;
        drop      = 1'b0;
        byte_len  = '0;
        case (state)
            ST_SYNC: begin
                if (beat && TLAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (beat) begin
                    if (mem_ready) begin
                        wr_en = 1'b1;
                        if (TLAST) begin
                            done     = 1'b1;
                            byte_len = tlast_len;
                        end else begin
                            addr_nxt  = ADDR_WIDTH'(1);
                            state_nxt = ST_CAPTURE;
                        end
                    end else begin
                        drop = 1'b1;
                        if (!TLAST) begin
                            state_nxt = ST_DISCARD;
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (beat) begin
                    if (mem_ready) begin
                        wr_en = 1'b1;
                        if (TLAST) begin
                            done      = 1'b1;
                            byte_len  = tlast_len;
                            addr_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end else if (addr == ADDR_LAST) begin
                            // Memory full: close out what fits, skip the rest of the packet.
                            done      = 1'b1;
                            trunc     = 1'b1;
                            byte_len  = FULL_LEN;
                            addr_nxt  = '0;
                            state_nxt = ST_DISCARD;
                        end else begin
                            addr_nxt = addr + ADDR_WIDTH'(1);
                        end
                    end else begin
                        drop      = 1'b1;
                        addr_nxt  = '0;
                        state_nxt = TLAST ? ST_IDLE : ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (beat && TLAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_RESET;
                addr_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

`ifdef SNOOP_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (done) begin
                pkt_cnt <= sat_inc(pkt_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign pkt_count  = pkt_cnt;
    assign drop_count = drop_cnt;
`else
    assign pkt_count  = 32'd0;
    assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_axistream_packet_snooper.sv
// Bench for axistream_packet_snooper: a deep instance (512 beats) and a shallow one (4 beats) share one
// stimulus stream; expectations come from packet-level rules (beat index, first not-ready beat, depth).
module tb_axistream_packet_snooper;

    localparam int DW  = 64;
    localparam int BPB = DW / 8;
    localparam int AWA = 9;
    localparam int AWB = 2;
    localparam int DEPTH_A = 2 ** AWA;
    localparam int DEPTH_B = 2 ** AWB;
`ifdef SNOOP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] TDATA;
    logic [7:0]    TKEEP;
    logic          TVALID, TREADY, TLAST, mem_ready;

    logic [AWA-1:0] a_wr_addr;
    logic [DW-1:0]  a_wr_data;
    logic           a_wr_en, a_done, a_trunc, a_drop;
    logic [12:0]    a_byte_len;
    logic [31:0]    a_pkt_count, a_drop_count;

    logic [AWB-1:0] b_wr_addr;
    logic [DW-1:0]  b_wr_data;
    logic           b_wr_en, b_done, b_trunc, b_drop;
    logic [5:0]     b_byte_len;
    logic [31:0]    b_pkt_count, b_drop_count;

    int n_assert = 0;
    int n_fail   = 0;
    int pc[2];
    int dc[2];

    always #5 clk = ~clk;

    axistream_packet_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWA), .WAIT_FOR_SOP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID), .TREADY(TREADY),
        .TLAST(TLAST), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_en(a_wr_en), .mem_ready(mem_ready),
        .done(a_done), .byte_len(a_byte_len), .trunc(a_trunc), .drop(a_drop),
        .pkt_count(a_pkt_count), .drop_count(a_drop_count)
    );

    axistream_packet_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB), .WAIT_FOR_SOP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID), .TREADY(TREADY),
        .TLAST(TLAST), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_en(b_wr_en), .mem_ready(mem_ready),
        .done(b_done), .byte_len(b_byte_len), .trunc(b_trunc), .drop(b_drop),
        .pkt_count(b_pkt_count), .drop_count(b_drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat i of an L-beat packet whose first not-ready beat is f (f >= L: never), memory depth D.
    function automatic void model(input int D, input int i, input int L, input int f, input int pop,
                                  input bit ign, input bit is_beat,
                                  output bit we, output bit dn, output bit tr, output bit dp,
                                  output int addr, output int blen);
        we = 0; dn = 0; tr = 0; dp = 0; addr = 0; blen = 0;
        if (ign) return;
        if (i <= f && i < D) addr = i;
        if (!is_beat) return;
        we = (i < f) && (i < D);
        dp = (i == f) && (f < D);
        if (L <= D) begin
            dn   = (i == L - 1) && (i < f);
            blen = (L - 1) * BPB + pop;
        end else begin
            dn   = (i == D - 1) && (i < f);
            tr   = dn;
            blen = D * BPB;
        end
    endfunction

    task automatic check_cycle(input string step, input int i, input int L, input int f, input int pop,
                               input bit ign, input bit is_beat);
        for (int d = 0; d < 2; d++) begin
            bit we, dn, tr, dp;
            int addr, blen;
            logic ow, od, ot, op;
            logic [63:0] oa, ob, owd, opc, odc;
            string t;
            t = (d == 0) ? {step, "/A"} : {step, "/B"};
            model((d == 0) ? DEPTH_A : DEPTH_B, i, L, f, pop, ign, is_beat, we, dn, tr, dp, addr, blen);
            if (d == 0) begin
                ow = a_wr_en; od = a_done; ot = a_trunc; op = a_drop;
                oa = 64'(a_wr_addr); ob = 64'(a_byte_len); owd = a_wr_data;
                opc = 64'(a_pkt_count); odc = 64'(a_drop_count);
            end else begin
                ow = b_wr_en; od = b_done; ot = b_trunc; op = b_drop;
                oa = 64'(b_wr_addr); ob = 64'(b_byte_len); owd = b_wr_data;
                opc = 64'(b_pkt_count); odc = 64'(b_drop_count);
            end
            chk({t, ".wr_en"}, 64'(ow), 64'(we));
            chk({t, ".done"}, 64'(od), 64'(dn));
            chk({t, ".trunc"}, 64'(ot), 64'(tr));
            chk({t, ".drop"}, 64'(op), 64'(dp));
            chk({t, ".wr_addr"}, oa, 64'(addr));
            chk({t, ".wr_data"}, owd, TDATA);
            if (dn) chk({t, ".byte_len"}, ob, 64'(blen));
            chk({t, ".pkt_count"}, opc, STATS ? 64'(pc[d]) : 64'd0);
            chk({t, ".drop_count"}, odc, STATS ? 64'(dc[d]) : 64'd0);
            if (dn) pc[d]++;
            if (dp) dc[d]++;
        end
    endtask

    // Non-beat cycles: TVALID may be high but TREADY is then low.
    task automatic idle_cycles(input string step, input int n, input int i, input int L, input int f,
                               input int pop, input bit ign, input bit force_valid);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            TVALID    = force_valid ? 1'b1 : 1'($urandom);
            TREADY    = TVALID ? 1'b0 : 1'($urandom);
            TLAST     = 1'($urandom);
            mem_ready = 1'($urandom);
            TKEEP     = 8'($urandom);
            TDATA     = {$urandom, $urandom};
            #1 check_cycle(step, i, L, f, pop, ign, 1'b0);
        end
    endtask

    task automatic send_packet(input string step, input int L, input int f, input logic [7:0] keep,
                               input bit ign, input int stall_max, input int first, input int last);
        int pop;
        pop = $countones(keep);
        for (int i = first; i <= last; i++) begin
            if (stall_max > 0) idle_cycles(step, $urandom_range(stall_max, 0), i, L, f, pop, ign, 1'b0);
            @(negedge clk);
            TVALID    = 1'b1;
            TREADY    = 1'b1;
            TLAST     = (i == L - 1);
            TKEEP     = (i == L - 1) ? keep : 8'($urandom);
            mem_ready = (i < f) ? 1'b1 : ((i == f) ? 1'b0 : 1'($urandom));
            TDATA     = {$urandom, $urandom};
            #1 check_cycle(step, i, L, f, pop, ign, 1'b1);
        end
    endtask

    task automatic do_reset(input string step);
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        TVALID    = 1'b1;
        TREADY    = 1'b1;
        TLAST     = 1'b0;
        mem_ready = 1'b1;
        pc[0] = 0; pc[1] = 0; dc[0] = 0; dc[1] = 0;
        #1 check_cycle(step, 0, 1, 1, 0, 1'b1, 1'b1);
        @(negedge clk);
        #1 check_cycle(step, 0, 1, 1, 0, 1'b1, 1'b1);
        TVALID = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int L, f;
        rst_n = 1'b0;
        TDATA = '0; TKEEP = '0; TVALID = 1'b0; TREADY = 1'b0; TLAST = 1'b0; mem_ready = 1'b0;
        pc[0] = 0; pc[1] = 0; dc[0] = 0; dc[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_cycle("reset", 0, 1, 1, 0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Joined mid-stream: first packet is skipped, the next one is captured
        send_packet("t1_sync", 3, 3, 8'hFF, 1'b1, 0, 0, 2);
        send_packet("t1", 4, 4, 8'h0F, 1'b0, 0, 0, 3);
        idle_cycles("gap", 2, 0, 1, 1, 0, 1'b0, 1'b0);

        send_packet("t2", 1, 1, 8'hFF, 1'b0, 0, 0, 0);
        send_packet("t2b", 2, 2, 8'h01, 1'b0, 0, 0, 1);

        send_packet("t3", 6, 2, 8'hFF, 1'b0, 0, 0, 5);
        send_packet("t3b", 3, 3, 8'hFF, 1'b0, 0, 0, 2);

        send_packet("t4", 6, 6, 8'hFF, 1'b0, 0, 0, 5);
        idle_cycles("gap", 1, 0, 1, 1, 0, 1'b0, 1'b0);

        send_packet("t5", 5, 5, 8'h3F, 1'b0, 0, 0, 1);
        idle_cycles("t5_stall", 5, 2, 5, 5, 6, 1'b0, 1'b1);
        send_packet("t5", 5, 5, 8'h3F, 1'b0, 0, 2, 4);

        send_packet("keep0", 3, 3, 8'h00, 1'b0, 0, 0, 2);
        send_packet("drop_first", 3, 0, 8'hFF, 1'b0, 0, 0, 2);
        send_packet("drop_single", 1, 0, 8'hFF, 1'b0, 0, 0, 0);
        send_packet("exact_depth", 4, 4, 8'h07, 1'b0, 0, 0, 3);
        send_packet("drop_after_trunc", 7, 5, 8'hFF, 1'b0, 0, 0, 6);

        send_packet("t6", 5, 5, 8'hFF, 1'b0, 0, 0, 1);
        do_reset("t6_rst");
        send_packet("t6_sync", 5, 5, 8'hFF, 1'b1, 0, 2, 4);
        send_packet("t6b", 2, 2, 8'hF0, 1'b0, 0, 0, 1);

        for (int k = 0; k < 40; k++) begin
            L = $urandom_range(7, 1);
            f = ($urandom_range(3, 0) == 0) ? $urandom_range(L - 1, 0) : L;
            send_packet("rnd", L, f, 8'($urandom), 1'b0, 2, 0, L - 1);
            idle_cycles("rnd_gap", $urandom_range(2, 0), 0, 1, 1, 0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
